// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: FSM state encoding and the
// per-stage enable/flush bundle with its fixed decode patterns.
package pipe_ctrl_pkg;

   localparam int unsigned REG_ADDR_W = 5;

   typedef enum logic [1:0] {
      HOLD     = 2'd0,
      RUN      = 2'd1,
      MEM_WAIT = 2'd2
   } ctrl_state_e;

   typedef struct packed {
      logic pc_en;
      logic if_id_en;
      logic id_ex_en;
      logic ex_mem_en;
      logic mem_wb_en;
      logic if_id_flush;
      logic id_ex_flush;
      logic ex_mem_flush;
      logic mem_wb_flush;
   } stage_ctrl_t;

   localparam stage_ctrl_t CTRL_HOLD     = 9'b00000_1111;
   localparam stage_ctrl_t CTRL_RUN      = 9'b11111_0000;
   localparam stage_ctrl_t CTRL_FREEZE   = 9'b00000_0001;
   localparam stage_ctrl_t CTRL_REDIRECT = 9'b11111_1100;
   // Bubble into ID/EX; the flush wins over its enable.
   localparam stage_ctrl_t CTRL_LOADUSE  = 9'b00111_0100;
   localparam stage_ctrl_t CTRL_ABANDON  = 9'b11111_0010;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bus: pipeline status in, stage controls out.
// Counter outputs exist only when PIPE_HAZARD_CTRL_PERF_EN is defined.
interface pipe_hazard_ctrl_if
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned P_CNT_W = 32
);

   logic [REG_ADDR_W-1:0] i_id_rs1_addr;
   logic [REG_ADDR_W-1:0] i_id_rs2_addr;
   logic                  i_id_rs1_used;
   logic                  i_id_rs2_used;
   logic                  i_ex_mem_read;
   logic [REG_ADDR_W-1:0] i_ex_rd_addr;
   logic                  i_ex_redirect;
   logic                  i_mem_req;
   logic                  i_dmem_ready;

   logic o_pc_en;
   logic o_if_id_en, o_id_ex_en, o_ex_mem_en, o_mem_wb_en;
   logic o_if_id_flush, o_id_ex_flush, o_ex_mem_flush, o_mem_wb_flush;
   logic o_mem_fault;
   logic [1:0] o_state;

`ifdef PIPE_HAZARD_CTRL_PERF_EN
   logic [P_CNT_W-1:0] o_cnt_stall_mem, o_cnt_loaduse, o_cnt_flush;
`endif

   if (P_CNT_W < 1 || P_CNT_W > 64) begin : g_bad_cnt_w
      $error("P_CNT_W out of range");
   end

   modport master (
      output i_id_rs1_addr, i_id_rs2_addr, i_id_rs1_used, i_id_rs2_used,
      output i_ex_mem_read, i_ex_rd_addr, i_ex_redirect, i_mem_req, i_dmem_ready,
`ifdef PIPE_HAZARD_CTRL_PERF_EN
      input  o_cnt_stall_mem, o_cnt_loaduse, o_cnt_flush,
`endif
      input  o_pc_en, o_if_id_en, o_id_ex_en, o_ex_mem_en, o_mem_wb_en,
      input  o_if_id_flush, o_id_ex_flush, o_ex_mem_flush, o_mem_wb_flush,
      input  o_mem_fault, o_state
   );

   modport slave (
      input  i_id_rs1_addr, i_id_rs2_addr, i_id_rs1_used, i_id_rs2_used,
      input  i_ex_mem_read, i_ex_rd_addr, i_ex_redirect, i_mem_req, i_dmem_ready,
`ifdef PIPE_HAZARD_CTRL_PERF_EN
      output o_cnt_stall_mem, o_cnt_loaduse, o_cnt_flush,
`endif
      output o_pc_en, o_if_id_en, o_id_ex_en, o_ex_mem_en, o_mem_wb_en,
      output o_if_id_flush, o_id_ex_flush, o_ex_mem_flush, o_mem_wb_flush,
      output o_mem_fault, o_state
   );

endinterface

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Combinational load-use comparator between the load in EX and the ID sources.
module hazard_detect
   import pipe_ctrl_pkg::*;
(
   input  logic [REG_ADDR_W-1:0] i_rs1_addr,
   input  logic [REG_ADDR_W-1:0] i_rs2_addr,
   input  logic                  i_rs1_used,
   input  logic                  i_rs2_used,
   input  logic                  i_ex_mem_read,
   input  logic [REG_ADDR_W-1:0] i_ex_rd_addr,
   output logic                  o_load_use
);

   // x0 is hardwired, so a load targeting it never produces a dependency.
   assign o_load_use = i_ex_mem_read && (i_ex_rd_addr != '0) &&
                       ((i_rs1_used && (i_rs1_addr == i_ex_rd_addr)) ||
                        (i_rs2_used && (i_rs2_addr == i_ex_rd_addr)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline register sequencer: reset hold, load-use bubble, redirect flush and
// data-memory freeze with timeout. Optional counters: PIPE_HAZARD_CTRL_PERF_EN.
module pipe_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned P_RESET_HOLD  = 4,
   parameter int unsigned P_MEM_TIMEOUT = 255,
   parameter int unsigned P_CNT_W       = 32
) (
   input  logic              i_clk,
   input  logic              i_arst_n,
   pipe_hazard_ctrl_if.slave bus
);

   localparam int unsigned WAIT_W = 16;

   if (P_RESET_HOLD < 1 || P_RESET_HOLD > 15) begin : g_bad_hold
      $error("P_RESET_HOLD out of range");
   end
   if (P_MEM_TIMEOUT < 1 || P_MEM_TIMEOUT > 65535) begin : g_bad_timeout
      $error("P_MEM_TIMEOUT out of range");
   end
   if (P_CNT_W < 1 || P_CNT_W > 64) begin : g_bad_cnt_w
      $error("P_CNT_W out of range");
   end

   ctrl_state_e       state_q, state_d;
   logic [3:0]        hold_q, hold_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic              fault_q, fault_d;
   logic              load_use, stall;
   stage_ctrl_t       run_ctrl, ctrl;

   hazard_detect u_hazard_detect (
      .i_rs1_addr    (bus.i_id_rs1_addr),
      .i_rs2_addr    (bus.i_id_rs2_addr),
      .i_rs1_used    (bus.i_id_rs1_used),
      .i_rs2_used    (bus.i_id_rs2_used),
      .i_ex_mem_read (bus.i_ex_mem_read),
      .i_ex_rd_addr  (bus.i_ex_rd_addr),
      .o_load_use    (load_use)
   );

   assign stall = bus.i_mem_req && !bus.i_dmem_ready;

   // Decode of an unstalled RUN cycle; redirect squashes the dependent instruction.
   always_comb begin
      run_ctrl = CTRL_RUN;
      if (bus.i_ex_redirect) begin
         run_ctrl = CTRL_REDIRECT;
      end else if (load_use) begin
         run_ctrl = CTRL_LOADUSE;
      end
   end

   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      wait_d  = wait_q;
      fault_d = fault_q;
      ctrl    = CTRL_HOLD;
      unique case (state_q)
         HOLD: begin
            hold_d = hold_q + 4'd1;
            if (hold_q == 4'(P_RESET_HOLD - 1)) begin
               state_d = RUN;
               hold_d  = '0;
            end
         end
         RUN: begin
            if (stall) begin
               ctrl    = CTRL_FREEZE;
               state_d = MEM_WAIT;
               wait_d  = WAIT_W'(1);
            end else begin
               ctrl = run_ctrl;
            end
         end
         MEM_WAIT: begin
            if (bus.i_dmem_ready) begin
               ctrl    = run_ctrl;
               state_d = RUN;
            end else if (wait_q == WAIT_W'(P_MEM_TIMEOUT)) begin
               ctrl    = CTRL_ABANDON;
               fault_d = 1'b1;
               state_d = RUN;
            end else begin
               ctrl   = CTRL_FREEZE;
               wait_d = wait_q + WAIT_W'(1);
            end
         end
         default: state_d = HOLD;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n) begin
         state_q <= HOLD;
         hold_q  <= '0;
         wait_q  <= '0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         wait_q  <= wait_d;
         fault_q <= fault_d;
      end
   end

   assign bus.o_pc_en        = ctrl.pc_en;
   assign bus.o_if_id_en     = ctrl.if_id_en;
   assign bus.o_id_ex_en     = ctrl.id_ex_en;
   assign bus.o_ex_mem_en    = ctrl.ex_mem_en;
   assign bus.o_mem_wb_en    = ctrl.mem_wb_en;
   assign bus.o_if_id_flush  = ctrl.if_id_flush;
   assign bus.o_id_ex_flush  = ctrl.id_ex_flush;
   assign bus.o_ex_mem_flush = ctrl.ex_mem_flush;
   assign bus.o_mem_wb_flush = ctrl.mem_wb_flush;
   assign bus.o_mem_fault    = fault_q;
   assign bus.o_state        = state_q;

`ifdef PIPE_HAZARD_CTRL_PERF_EN
   logic               resolving, evt_stall, evt_loaduse, evt_redirect;
   logic [P_CNT_W-1:0] cnt_stall_q, cnt_loaduse_q, cnt_flush_q;

   assign resolving    = ((state_q == RUN) && !stall) ||
                         ((state_q == MEM_WAIT) && bus.i_dmem_ready);
   assign evt_stall    = ((state_q == RUN) && stall) || (state_q == MEM_WAIT);
   assign evt_redirect = resolving && bus.i_ex_redirect;
   assign evt_loaduse  = resolving && !bus.i_ex_redirect && load_use;

   always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n) begin
         cnt_stall_q   <= '0;
         cnt_loaduse_q <= '0;
         cnt_flush_q   <= '0;
      end else begin
         if (evt_stall && !(&cnt_stall_q))     cnt_stall_q   <= cnt_stall_q + P_CNT_W'(1);
         if (evt_loaduse && !(&cnt_loaduse_q)) cnt_loaduse_q <= cnt_loaduse_q + P_CNT_W'(1);
         if (evt_redirect && !(&cnt_flush_q))  cnt_flush_q   <= cnt_flush_q + P_CNT_W'(1);
      end
   end

   assign bus.o_cnt_stall_mem = cnt_stall_q;
   assign bus.o_cnt_loaduse   = cnt_loaduse_q;
   assign bus.o_cnt_flush     = cnt_flush_q;
`endif

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central sequencer for the 5-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Generates per-register enable and flush controls, and the PC enable.
- Resolves three hazard classes: load-use (one bubble), EX-stage redirect (two-instruction flush) and data-memory wait (full freeze with a timeout).
- Holds the pipeline flushed for a fixed number of cycles after reset release.

Parameters:
P_RESET_HOLD, 4, cycles the pipeline is held flushed after reset deassertion (1..15)
P_MEM_TIMEOUT, 255, max consecutive MEM_WAIT cycles before fault (1..65535)
P_CNT_W, 32, width of the performance counters (only used when the optional feature is enabled)

Ports:
i_clk  in  1  clock
i_arst_n  in  1  async reset, active-low
i_id_rs1_addr  in  5  rs1 of instruction in ID
i_id_rs2_addr  in  5  rs2 of instruction in ID
i_id_rs1_used  in  1  ID instruction reads rs1
i_id_rs2_used  in  1  ID instruction reads rs2
i_ex_mem_read  in  1  instruction in EX is a load
i_ex_rd_addr  in  5  rd of instruction in EX
i_ex_redirect  in  1  EX resolved taken branch/jump
i_mem_req  in  1  instruction in MEM accesses data memory
i_dmem_ready  in  1  data memory completes access this cycle
o_pc_en  out  1  PC update enable
o_if_id_en, o_id_ex_en, o_ex_mem_en, o_mem_wb_en  out  1 each  register load enables
o_if_id_flush, o_id_ex_flush, o_ex_mem_flush, o_mem_wb_flush  out  1 each  synchronous clear-to-bubble
o_mem_fault  out  1  sticky timeout flag
o_state  out  2  FSM state for debug

Behaviour:
- Reset: i_arst_n (asynchronous, active-low), clock i_clk.
  - While in reset: state=HOLD, hold counter=0, wait counter=0, o_mem_fault=0, o_state=2'd0.
  - Reset values of the enable/flush outputs follow the HOLD decode: all enables 0, all flushes 1.
- FSM states (o_state encoding): HOLD=0, RUN=1, MEM_WAIT=2.
- All control outputs are combinational from the state and inputs. The state, the counters and o_mem_fault are registered.
- HOLD:
  - All enables 0, all flushes 1.
  - The counter increments every cycle. At count P_RESET_HOLD-1 the FSM moves to RUN.
  - Inputs are ignored.
- RUN: evaluate the conditions in this priority order.
  1. Memory stall. Condition: i_mem_req && !i_dmem_ready.
     - All enables 0, o_mem_wb_flush=1, other flushes 0.
     - Next state MEM_WAIT; the wait counter is loaded with 1.
  2. Redirect. Condition: i_ex_redirect.
     - All enables 1, o_if_id_flush=1, o_id_ex_flush=1.
     - Overrides load-use, because the dependent instruction is squashed.
  3. Load-use. Condition: i_ex_mem_read && i_ex_rd_addr!=0 && ((i_id_rs1_used && rs1==rd) || (i_id_rs2_used && rs2==rd)).
     - o_pc_en=0, o_if_id_en=0, o_id_ex_flush=1.
     - EX/MEM and MEM/WB are enabled.
  4. Otherwise: all enables 1, no flushes.
- MEM_WAIT:
  - Freeze as in case 1 (all enables 0, o_mem_wb_flush=1). Redirect and load-use inputs are ignored.
  - On i_dmem_ready: this cycle behaves as RUN with the stall condition false (the same priority rules apply), and the next state is RUN.
  - Otherwise the wait counter increments. When it reaches P_MEM_TIMEOUT: o_mem_fault<=1 (sticky until reset), the current access is abandoned, o_ex_mem_flush=1 and all enables 1 that cycle, and the next state is RUN.
- x0 never creates a load-use hazard.
- Every flush takes precedence over the enable of the same register.

Optional Feature:
PIPE_HAZARD_CTRL_PERF_EN
- Defined: adds outputs o_cnt_stall_mem, o_cnt_loaduse and o_cnt_flush (each P_CNT_W bits, reset 0, saturating at all-ones).
  - o_cnt_stall_mem increments each MEM_WAIT cycle plus the entry cycle.
  - o_cnt_loaduse increments each load-use bubble.
  - o_cnt_flush increments each redirect.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Package pipe_ctrl_pkg:
  - state enum ctrl_state_e {HOLD, RUN, MEM_WAIT}, 2-bit encoding as above.
  - REG_ADDR_W=5 and the stage-control struct type (en/flush per stage).
- One sub-module, hazard_detect: the pure combinational load-use comparator. The FSM and counters stay in the top module.

Test Plan:
- Reset with P_RESET_HOLD=4 -> all enables 0 and flushes 1 for exactly 4 cycles after deassertion, then o_state=1 and all enables 1.
- EX load with rd=5, ID rs2=5 used -> exactly one cycle of o_pc_en=0, o_if_id_en=0, o_id_ex_flush=1. Same with rd=0 -> no stall.
- Load-use and i_ex_redirect asserted together -> o_if_id_flush=o_id_ex_flush=1, o_pc_en=1, no bubble.
- i_mem_req=1 with i_dmem_ready low for 3 cycles -> 3 freeze cycles with o_mem_wb_flush=1 and o_state=2, resume in the cycle ready rises.
- P_MEM_TIMEOUT=8, ready never asserted -> o_mem_fault rises after the 8th wait cycle, o_ex_mem_flush pulses, FSM returns to RUN, and the fault stays set until reset.
- i_arst_n asserted mid MEM_WAIT -> immediate HOLD, o_mem_fault cleared, and the hold sequence restarts.
